// File: rtl/cgra_mem_pkg.sv
// Shared types and defaults for the PE memory arbiter: FSM states,
// default geometry and the data returned on a timed-out read.
package cgra_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_NUM_PE  = 4;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    localparam logic [63:0] ERR_DATA = 64'h0;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// returned both as a one-hot grant and as an index.
module rr_arbiter
    import cgra_mem_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE
) (
    input  logic [NUM_PE-1:0]            req,
    input  logic [idx_w(NUM_PE)-1:0]     ptr,
    output logic [NUM_PE-1:0]            grant,
    output logic [idx_w(NUM_PE)-1:0]     idx
);

    localparam int IW = idx_w(NUM_PE);

    logic [IW-1:0] cand_s;
    logic          found_s;

    // Scan requesters in rotating order starting at the pointer.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand_s = IW'((int'(ptr) + i) % NUM_PE);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Shares one downstream memory read port among NUM_PE controllers with
// round-robin grants, a per-transaction timeout and a sticky error flag.
module pe_mem_arbiter
    import cgra_mem_pkg::*;
#(
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PE-1:0]            pe_mem_read,
    input  logic [NUM_PE*AW-1:0]         pe_mem_address,
    output logic [NUM_PE-1:0]            pe_mem_ack,
    output logic [DW-1:0]                pe_mem_Message,
    output logic                         mem_read,
    output logic [AW-1:0]                mem_address,
    input  logic                         mem_ack,
    input  logic [DW-1:0]                mem_Message,
    output logic [idx_w(NUM_PE)-1:0]     grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int IW = idx_w(NUM_PE);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0]     IDX_LAST = IW'(NUM_PE - 1);
    localparam logic [NUM_PE-1:0] PE_ONE   = NUM_PE'(1'b1);

    state_t            state_r, state_s;
    logic              mem_read_r, mem_read_s;
    logic [AW-1:0]     addr_r, addr_s;
    logic [NUM_PE-1:0] ack_r, ack_s;
    logic [DW-1:0]     msg_r, msg_s;
    logic [IW-1:0]     grant_r, grant_s;
    logic              busy_r;
    logic              err_r, err_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [NUM_PE-1:0] mask_r, mask_s;
    logic [IW-1:0]     last_r, last_s;

    logic [NUM_PE-1:0] req_m_s;
    logic [IW-1:0]     ptr_s;
    logic [NUM_PE-1:0] arb_grant_s;
    logic [IW-1:0]     arb_idx_s;
    logic [AW-1:0]     addr_sel_s;

    assign req_m_s = pe_mem_read & ~mask_r;
    assign ptr_s   = (last_r == IDX_LAST) ? '0 : last_r + IW'(1);

    rr_arbiter #(.NUM_PE(NUM_PE)) u_rr (
        .req   (req_m_s),
        .ptr   (ptr_s),
        .grant (arb_grant_s),
        .idx   (arb_idx_s)
    );

    // Address of the winning requester, selected by the one-hot grant.
    always_comb begin
        addr_sel_s = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            addr_sel_s = addr_sel_s | ({AW{arb_grant_s[i]}} & pe_mem_address[i*AW +: AW]);
        end
    end

    // Next-state and next-output logic; everything below lands in registers.
    always_comb begin
        state_s    = state_r;
        mem_read_s = mem_read_r;
        addr_s     = addr_r;
        ack_s      = '0;
        msg_s      = msg_r;
        grant_s    = grant_r;
        err_s      = err_r;
        cnt_s      = cnt_r;
        mask_s     = mask_r;
        last_s     = last_r;
        case (state_r)
            IDLE: begin
                mask_s = '0;
                if (|req_m_s) begin
                    state_s    = ISSUE;
                    grant_s    = arb_idx_s;
                    addr_s     = addr_sel_s;
                    mem_read_s = 1'b1;
                    cnt_s      = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    msg_s      = mem_Message;
                    ack_s      = PE_ONE << grant_r;
                    mem_read_s = 1'b0;
                    state_s    = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    err_s      = 1'b1;
                    msg_s      = DW'(ERR_DATA);
                    ack_s      = PE_ONE << grant_r;
                    mem_read_s = 1'b0;
                    state_s    = RESP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            RESP: begin
                // The served PE is still lowering its request next cycle.
                last_s  = grant_r;
                mask_s  = PE_ONE << grant_r;
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                mem_read_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset gives PE0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            mem_read_r <= 1'b0;
            addr_r     <= '0;
            ack_r      <= '0;
            msg_r      <= '0;
            grant_r    <= '0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            cnt_r      <= '0;
            mask_r     <= '0;
            last_r     <= IDX_LAST;
        end else begin
            state_r    <= state_s;
            mem_read_r <= mem_read_s;
            addr_r     <= addr_s;
            ack_r      <= ack_s;
            msg_r      <= msg_s;
            grant_r    <= grant_s;
            busy_r     <= (state_s != IDLE);
            err_r      <= err_s;
            cnt_r      <= cnt_s;
            mask_r     <= mask_s;
            last_r     <= last_s;
        end
    end

    assign mem_read       = mem_read_r;
    assign mem_address    = addr_r;
    assign pe_mem_ack     = ack_r;
    assign pe_mem_Message = msg_r;
    assign grant_id       = grant_r;
    assign busy           = busy_r;
    assign timeout_err    = err_r;

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Directed bench for pe_mem_arbiter (4 PEs, TIMEOUT=8) with hand-computed
// expectations checked by immediate assertions.
module tb_pe_mem_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    pe_mem_read;
    logic [127:0]  pe_mem_address;
    logic [3:0]    pe_mem_ack;
    logic [31:0]   pe_mem_Message;
    logic          mem_read;
    logic [31:0]   mem_address;
    logic          mem_ack;
    logic [31:0]   mem_Message;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    pe_mem_arbiter #(.NUM_PE(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_mem_read    (pe_mem_read),
        .pe_mem_address (pe_mem_address),
        .pe_mem_ack     (pe_mem_ack),
        .pe_mem_Message (pe_mem_Message),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_ack        (mem_ack),
        .mem_Message    (mem_Message),
        .grant_id       (grant_id),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst            = 1'b1;
        pe_mem_read    = 4'b0000;
        pe_mem_address = 128'h0;
        mem_ack        = 1'b0;
        mem_Message    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_ack", pe_mem_ack, 4'b0000);
        chk("rst_msg", pe_mem_Message, 32'h0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", timeout_err, 1'b0);
        rst = 1'b0;

        // Single request from PE2, mem_ack on the second ISSUE cycle.
        pe_mem_read               = 4'b0100;
        pe_mem_address[64 +: 32]  = 32'h40;
        tick();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_address", mem_address, 32'h40);
        chk("t1_grant", grant_id, 2'd2);
        chk("t1_busy", busy, 1'b1);
        tick();
        chk("t1_wait_read", mem_read, 1'b1);
        chk("t1_wait_ack", pe_mem_ack, 4'b0000);
        mem_ack     = 1'b1;
        mem_Message = 32'h1234;
        tick();
        chk("t1_ack", pe_mem_ack, 4'b0100);
        chk("t1_msg", pe_mem_Message, 32'h1234);
        chk("t1_read_drop", mem_read, 1'b0);
        mem_ack     = 1'b0;
        pe_mem_read = 4'b0000;
        tick();
        chk("t1_ack_gone", pe_mem_ack, 4'b0000);
        chk("t1_idle", busy, 1'b0);

        // Stray mem_ack while idle must be ignored.
        mem_ack     = 1'b1;
        mem_Message = 32'hDEAD;
        tick();
        tick();
        chk("stray_read", mem_read, 1'b0);
        chk("stray_ack", pe_mem_ack, 4'b0000);
        chk("stray_msg", pe_mem_Message, 32'h1234);
        chk("stray_busy", busy, 1'b0);
        chk("stray_grant", grant_id, 2'd2);
        mem_ack = 1'b0;

        // Reset in the middle of ISSUE abandons the transaction.
        pe_mem_read               = 4'b1000;
        pe_mem_address[96 +: 32]  = 32'h30;
        tick();
        chk("r_issue_grant", grant_id, 2'd3);
        chk("r_issue_read", mem_read, 1'b1);
        rst = 1'b1;
        #1;
        chk("r_async_read", mem_read, 1'b0);
        chk("r_async_busy", busy, 1'b0);
        tick();
        chk("r_no_ack", pe_mem_ack, 4'b0000);
        rst = 1'b0;

        // All PEs request continuously with immediate acks: 0,1,2,3,0.
        pe_mem_read    = 4'b1111;
        pe_mem_address = {32'h3000, 32'h2000, 32'h1000, 32'h0800};
        mem_ack        = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_Message = 32'hA0 + 32'(k);
            tick();
            tick();
            chk("rr_grant", grant_id, 64'(k % 4));
            chk("rr_ack", pe_mem_ack, 64'(4'b0001 << (k % 4)));
            chk("rr_msg", pe_mem_Message, 64'(32'hA0 + 32'(k)));
            if (k == 4) begin
                pe_mem_read = 4'b0000;
                mem_ack     = 1'b0;
            end else begin
                tick();
            end
        end
        tick();
        tick();
        chk("rr_idle", busy, 1'b0);

        // PE1 alone, lowering its request one cycle after the ack.
        pe_mem_read              = 4'b0010;
        pe_mem_address[32 +: 32] = 32'h88;
        mem_ack                  = 1'b1;
        mem_Message              = 32'h55;
        tick();
        chk("s1_grant", grant_id, 2'd1);
        chk("s1_addr", mem_address, 32'h88);
        tick();
        chk("s1_ack", pe_mem_ack, 4'b0010);
        chk("s1_msg", pe_mem_Message, 32'h55);
        mem_ack = 1'b0;
        tick();
        tick();
        chk("s1_masked_busy", busy, 1'b0);
        chk("s1_masked_read", mem_read, 1'b0);
        pe_mem_read = 4'b0000;
        tick();
        chk("s1_no_regrant", busy, 1'b0);
        chk("s1_no_ack", pe_mem_ack, 4'b0000);

        // Timeout: no mem_ack, PE0 wins via pointer wrap, 8 ISSUE cycles.
        pe_mem_read             = 4'b0001;
        pe_mem_address[0 +: 32] = 32'h10;
        mem_Message             = 32'hBEEF;
        tick();
        chk("to_grant", grant_id, 2'd0);
        chk("to_read_1", mem_read, 1'b1);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("to_read_hold", mem_read, 1'b1);
        end
        chk("to_err_early", timeout_err, 1'b0);
        tick();
        chk("to_read_drop", mem_read, 1'b0);
        chk("to_ack", pe_mem_ack, 4'b0001);
        chk("to_msg", pe_mem_Message, 32'h0);
        chk("to_err", timeout_err, 1'b1);
        pe_mem_read = 4'b0000;
        tick();
        tick();
        tick();
        chk("to_err_sticky", timeout_err, 1'b1);
        chk("to_idle", busy, 1'b0);
        rst = 1'b1;
        #1;
        chk("to_err_clear", timeout_err, 1'b0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
